// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder: scans a 4x4 active-low keypad, debounces press/release, one code strobe per press
module keypad_scan_decoder #(
   parameter int SCAN_CYCLES     = 27000,
   parameter int DEBOUNCE_CYCLES = 540000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] col_in,
   output logic [3:0] row_out,
   output logic [3:0] KEY_Value,
   output logic       Value_en,
   output logic       key_down
);
   localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD} state_t;

   state_t          r_state, w_state;
   logic [3:0]      r_sync1, r_cs;
   logic [1:0]      r_row, w_row;
   logic [1:0]      r_col, w_col;
   logic [SW-1:0]   r_scan_cnt, w_scan_cnt;
   logic [DW-1:0]   r_deb_cnt, w_deb_cnt;
   logic [DW-1:0]   r_rel_cnt, w_rel_cnt;
   logic [3:0]      r_key, w_key;
   logic            r_value_en, w_value_en;
   logic            r_key_down, w_key_down;
   logic [1:0]      w_low_col;
   logic [3:0]      w_code;

   // two-flop synchroniser for the asynchronous column inputs; idles high like the pull-ups
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync1 <= 4'hF;
         r_cs    <= 4'hF;
      end else begin
         r_sync1 <= col_in;
         r_cs    <= r_sync1;
      end
   end

   // state and output registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= SCAN;
         r_row      <= 2'd0;
         r_col      <= 2'd0;
         r_scan_cnt <= '0;
         r_deb_cnt  <= '0;
         r_rel_cnt  <= '0;
         r_key      <= 4'd0;
         r_value_en <= 1'b0;
         r_key_down <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_row      <= w_row;
         r_col      <= w_col;
         r_scan_cnt <= w_scan_cnt;
         r_deb_cnt  <= w_deb_cnt;
         r_rel_cnt  <= w_rel_cnt;
         r_key      <= w_key;
         r_value_en <= w_value_en;
         r_key_down <= w_key_down;
      end
   end

   // lowest-index low column wins when several keys of one row are down
   always_comb begin
      w_low_col = !r_cs[0] ? 2'd0 : !r_cs[1] ? 2'd1 : !r_cs[2] ? 2'd2 : 2'd3;
   end

   // key code of the latched row/column position
   always_comb begin
      w_code = 4'd0;
      case ({r_row, r_col})
         4'h0: w_code = 4'd1;
         4'h1: w_code = 4'd2;
         4'h2: w_code = 4'd3;
         4'h3: w_code = 4'd11;
         4'h4: w_code = 4'd4;
         4'h5: w_code = 4'd5;
         4'h6: w_code = 4'd6;
         4'h7: w_code = 4'd12;
         4'h8: w_code = 4'd7;
         4'h9: w_code = 4'd8;
         4'hA: w_code = 4'd9;
         4'hB: w_code = 4'd13;
         4'hC: w_code = 4'd15;
         4'hD: w_code = 4'd0;
         4'hE: w_code = 4'd10;
         4'hF: w_code = 4'd14;
         default: w_code = 4'd0;
      endcase
   end

   // scan / press-debounce / held-until-release sequencing
   always_comb begin
      w_state    = r_state;
      w_row      = r_row;
      w_col      = r_col;
      w_scan_cnt = r_scan_cnt;
      w_deb_cnt  = r_deb_cnt;
      w_rel_cnt  = r_rel_cnt;
      w_key      = r_key;
      w_value_en = 1'b0;
      w_key_down = r_key_down;
      case (r_state)
         SCAN: begin
            if (r_scan_cnt == SCAN_LAST) begin
               w_scan_cnt = '0;
               if (r_cs == 4'hF) begin
                  w_row = r_row + 2'd1;
               end else begin
                  w_col     = w_low_col;
                  w_deb_cnt = '0;
                  w_state   = DEB_PRESS;
               end
            end else begin
               w_scan_cnt = r_scan_cnt + 1'b1;
            end
         end
         DEB_PRESS: begin
            if (r_cs[r_col]) begin
               w_scan_cnt = '0;
               w_state    = SCAN;
            end else if (r_deb_cnt == DEB_LAST) begin
               w_value_en = 1'b1;
               w_key      = w_code;
               w_key_down = 1'b1;
               w_rel_cnt  = '0;
               w_state    = HELD;
            end else begin
               w_deb_cnt = r_deb_cnt + 1'b1;
            end
         end
         HELD: begin
            if (r_cs != 4'hF) begin
               w_rel_cnt = '0;
            end else if (r_rel_cnt == DEB_LAST) begin
               w_key_down = 1'b0;
               w_row      = r_row + 2'd1;
               w_scan_cnt = '0;
               w_state    = SCAN;
            end else begin
               w_rel_cnt = r_rel_cnt + 1'b1;
            end
         end
         default: w_state = SCAN;
      endcase
   end

   assign row_out   = ~(4'b0001 << r_row);
   assign KEY_Value = r_key;
   assign Value_en  = r_value_en;
   assign key_down  = r_key_down;
endmodule
